// File: rtl/cache_axi_pkg.sv
// Shared types, AXI constants and burst-shape helpers for the cache line master.
package cache_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_CAP,
        WB_AW,
        WB_W,
        WB_B,
        RD_AR,
        RD_R,
        LD_OUT
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE encoding: log2 of the number of bytes in one data word.
    function automatic logic [2:0] axiSize(input int dataSize);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (dataSize / 8)) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

    // AxLEN encoding: beats per burst minus one, one burst per cache line.
    function automatic logic [7:0] axiLen(input int blockSize);
        return 8'((1 << blockSize) - 1);
    endfunction

endpackage

// File: rtl/axi_line_buffer.sv
// One cache line of storage: loaded/read as a whole on the cache side,
// written/read one word at a time on the AXI side.
module axi_line_buffer #(
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 6
) (
    input  logic                                  i_clk,
    input  logic                                  i_lineLoad,
    input  logic [(DATA_SIZE << BLOCK_SIZE)-1:0]  i_lineIn,
    output logic [(DATA_SIZE << BLOCK_SIZE)-1:0]  o_lineOut,
    input  logic                                  i_beatWrite,
    input  logic [BLOCK_SIZE-1:0]                 i_wrIdx,
    input  logic [DATA_SIZE-1:0]                  i_beatIn,
    input  logic [BLOCK_SIZE-1:0]                 i_rdIdx,
    output logic [DATA_SIZE-1:0]                  o_beatOut
);
    localparam int BLOCKS = 1 << BLOCK_SIZE;

    logic [DATA_SIZE-1:0] r_mem [BLOCKS];

    // Whole-line capture has priority over single-beat writes; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_lineLoad) begin
            for (int i = 0; i < BLOCKS; i++) begin
                r_mem[i] <= i_lineIn[i*DATA_SIZE +: DATA_SIZE];
            end
        end else if (i_beatWrite) begin
            r_mem[i_wrIdx] <= i_beatIn;
        end
    end

    for (genvar g = 0; g < BLOCKS; g++) begin : g_lineOut
        assign o_lineOut[g*DATA_SIZE +: DATA_SIZE] = r_mem[g];
    end

    assign o_beatOut = r_mem[i_rdIdx];

endmodule

// File: rtl/cache_axi_line_master.sv
// Memory-side end of the cache miss path: turns each line load or write-back
// into one AXI4 INCR burst of a full line, buffering the line locally.
module cache_axi_line_master
    import cache_axi_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  addr_valid_in,
    input  logic [ADDR_SIZE-1:0]                  addr_in,
    input  logic                                  rw_in,
    input  logic                                  valid_wb,
    input  logic [(DATA_SIZE << BLOCK_SIZE)-1:0]  data_in_c,
    output logic                                  ready_wb,
    output logic                                  valid_ld,
    output logic [(DATA_SIZE << BLOCK_SIZE)-1:0]  data_out_c,
    input  logic                                  ready_ld,
    output logic                                  busy,
    output logic                                  err_out,
    output logic                                  m_axi_awvalid,
    output logic [ADDR_SIZE-1:0]                  m_axi_awaddr,
    output logic [7:0]                            m_axi_awlen,
    output logic [2:0]                            m_axi_awsize,
    output logic [1:0]                            m_axi_awburst,
    input  logic                                  m_axi_awready,
    output logic                                  m_axi_wvalid,
    output logic [DATA_SIZE-1:0]                  m_axi_wdata,
    output logic [DATA_SIZE/8-1:0]                m_axi_wstrb,
    output logic                                  m_axi_wlast,
    input  logic                                  m_axi_wready,
    input  logic                                  m_axi_bvalid,
    input  logic [1:0]                            m_axi_bresp,
    output logic                                  m_axi_bready,
    output logic                                  m_axi_arvalid,
    output logic [ADDR_SIZE-1:0]                  m_axi_araddr,
    output logic [7:0]                            m_axi_arlen,
    output logic [2:0]                            m_axi_arsize,
    output logic [1:0]                            m_axi_arburst,
    input  logic                                  m_axi_arready,
    input  logic                                  m_axi_rvalid,
    input  logic [DATA_SIZE-1:0]                  m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    output logic                                  m_axi_rready
);
    localparam int                    BLOCKS    = 1 << BLOCK_SIZE;
    localparam int                    OFFS      = BLOCK_SIZE + $clog2(DATA_SIZE / 8);
    localparam logic [BLOCK_SIZE-1:0] LAST_BEAT = BLOCK_SIZE'(BLOCKS - 1);
    localparam logic [ADDR_SIZE-1:0]  LINE_MASK = ~ADDR_SIZE'((64'd1 << OFFS) - 64'd1);

    state_t                  r_state, w_nextState;
    logic [BLOCK_SIZE-1:0]   r_beat, w_nextBeat;
    logic                    r_errFlag, w_nextErrFlag;
    logic [ADDR_SIZE-1:0]    r_addr;
    logic                    r_awValid, r_wValid, r_wLast, r_bReady;
    logic                    r_arValid, r_rReady, r_validLd, r_readyWb, r_busy;
    logic [DATA_SIZE-1:0]    r_wData;
    logic                    w_capture, w_rBeatWrite;
    logic [DATA_SIZE-1:0]    w_bufBeat;

    assign w_capture    = (r_state == WB_CAP) && valid_wb && r_readyWb;
    assign w_rBeatWrite = (r_state == RD_R) && m_axi_rvalid && r_rReady;

    axi_line_buffer #(
        .DATA_SIZE  (DATA_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_lineBuffer (
        .i_clk       (clk),
        .i_lineLoad  (w_capture),
        .i_lineIn    (data_in_c),
        .o_lineOut   (data_out_c),
        .i_beatWrite (w_rBeatWrite),
        .i_wrIdx     (r_beat),
        .i_beatIn    (m_axi_rdata),
        .i_rdIdx     (w_nextBeat),
        .o_beatOut   (w_bufBeat)
    );

    // Sequencing of one line transfer; errors never cut a burst short.
    always_comb begin
        w_nextState   = r_state;
        w_nextBeat    = r_beat;
        w_nextErrFlag = r_errFlag;
        case (r_state)
            IDLE: begin
                if (addr_valid_in) begin
                    w_nextState = rw_in ? WB_CAP : RD_AR;
                end
            end
            WB_CAP: begin
                if (w_capture) begin
                    w_nextState = WB_AW;
                end
            end
            WB_AW: begin
                if (r_awValid && m_axi_awready) begin
                    w_nextState = WB_W;
                end
            end
            WB_W: begin
                if (r_wValid && m_axi_wready) begin
                    if (r_beat == LAST_BEAT) begin
                        w_nextBeat  = '0;
                        w_nextState = WB_B;
                    end else begin
                        w_nextBeat = r_beat + 1'b1;
                    end
                end
            end
            WB_B: begin
                if (m_axi_bvalid && r_bReady) begin
                    w_nextState = IDLE;
                end
            end
            RD_AR: begin
                if (r_arValid && m_axi_arready) begin
                    w_nextState = RD_R;
                end
            end
            RD_R: begin
                if (w_rBeatWrite) begin
                    if ((m_axi_rresp != AXI_RESP_OKAY) ||
                        (m_axi_rlast != (r_beat == LAST_BEAT))) begin
                        w_nextErrFlag = 1'b1;
                    end
                    if (r_beat == LAST_BEAT) begin
                        w_nextBeat  = '0;
                        w_nextState = LD_OUT;
                    end else begin
                        w_nextBeat = r_beat + 1'b1;
                    end
                end
            end
            LD_OUT: begin
                if (r_validLd && ready_ld) begin
                    w_nextErrFlag = 1'b0;
                    w_nextState   = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, beat counter and sticky read-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_errFlag <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_beat    <= w_nextBeat;
            r_errFlag <= w_nextErrFlag;
        end
    end

    // Handshake outputs are registered from the next state so each valid stays put until its ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awValid <= 1'b0;
            r_wValid  <= 1'b0;
            r_wLast   <= 1'b0;
            r_wData   <= '0;
            r_bReady  <= 1'b0;
            r_arValid <= 1'b0;
            r_rReady  <= 1'b0;
            r_validLd <= 1'b0;
            r_readyWb <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_awValid <= (w_nextState == WB_AW);
            r_wValid  <= (w_nextState == WB_W);
            r_wLast   <= (w_nextState == WB_W) && (w_nextBeat == LAST_BEAT);
            r_wData   <= w_bufBeat;
            r_bReady  <= (w_nextState == WB_B);
            r_arValid <= (w_nextState == RD_AR);
            r_rReady  <= (w_nextState == RD_R);
            r_validLd <= (w_nextState == LD_OUT);
            r_readyWb <= (w_nextState == WB_CAP);
            r_busy    <= (w_nextState != IDLE);
        end
    end

    // Line-aligned burst address, captured only when a new request is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if ((r_state == IDLE) && addr_valid_in) begin
            r_addr <= addr_in & LINE_MASK;
        end
    end

    assign err_out = ((r_state == WB_B) && m_axi_bvalid && r_bReady &&
                      (m_axi_bresp != AXI_RESP_OKAY)) ||
                     ((r_state == LD_OUT) && r_validLd && ready_ld && r_errFlag);

    assign ready_wb      = r_readyWb;
    assign valid_ld      = r_validLd;
    assign busy          = r_busy;
    assign m_axi_awvalid = r_awValid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = axiLen(BLOCK_SIZE);
    assign m_axi_awsize  = axiSize(DATA_SIZE);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wvalid  = r_wValid;
    assign m_axi_wdata   = r_wData;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wLast;
    assign m_axi_bready  = r_bReady;
    assign m_axi_arvalid = r_arValid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = axiLen(BLOCK_SIZE);
    assign m_axi_arsize  = axiSize(DATA_SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = r_rReady;

endmodule

// File: tb/tb_cache_axi_line_master.sv
// Bench for cache_axi_line_master: a reactive AXI slave, a line-level scoreboard
// checked every cycle, and directed requests with literal expectations.
module tb_cache_axi_line_master;
    localparam int BLOCKS = 64;
    localparam int LINE_W = 2048;

    logic              clk, rst;
    logic              addr_valid_in, rw_in, valid_wb, ready_ld;
    logic [31:0]       addr_in;
    logic [LINE_W-1:0] data_in_c, data_out_c;
    logic              ready_wb, valid_ld, busy, err_out;
    logic              m_axi_awvalid, m_axi_awready;
    logic [31:0]       m_axi_awaddr, m_axi_araddr;
    logic [7:0]        m_axi_awlen, m_axi_arlen;
    logic [2:0]        m_axi_awsize, m_axi_arsize;
    logic [1:0]        m_axi_awburst, m_axi_arburst;
    logic              m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic [31:0]       m_axi_wdata, m_axi_rdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_bvalid, m_axi_bready;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_arvalid, m_axi_arready;
    logic              m_axi_rvalid, m_axi_rlast, m_axi_rready;

    int checkCount = 0;
    int errorCount = 0;

    // Scoreboard model of the current request.
    logic [31:0]       modelAddr;
    logic [LINE_W-1:0] modelLine;
    logic              modelLdErr;
    int                wCnt, rCnt;
    logic              awDone, ldDueNow, ldDueNext, busyDueNow, busyDueNext;

    // Slave behaviour knobs.
    logic [31:0] cfgBase;
    int          cfgErrBeat, cfgLastBeat, cfgStall;
    logic        cfgGaps;

    cache_axi_line_master #(
        .ADDR_SIZE (32),
        .DATA_SIZE (32),
        .BLOCK_SIZE(6)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_valid_in(addr_valid_in), .addr_in(addr_in), .rw_in(rw_in),
        .valid_wb(valid_wb), .data_in_c(data_in_c), .ready_wb(ready_wb),
        .valid_ld(valid_ld), .data_out_c(data_out_c), .ready_ld(ready_ld),
        .busy(busy), .err_out(err_out),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // AXI slave: samples handshakes at negedge, reacts just after the next posedge.
    logic hsAr, hsAw, hsR, hsW, hsWLast, hsB, arWait, awWait, sawRst, rOn, wOn;
    int   rBeat, arWaitCnt, awWaitCnt;
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 0;
        rOn = 0; wOn = 0; rBeat = 0; arWaitCnt = 0; awWaitCnt = 0;
        forever begin
            @(negedge clk);
            sawRst  = rst;
            hsAr    = m_axi_arvalid && m_axi_arready;
            hsAw    = m_axi_awvalid && m_axi_awready;
            hsR     = m_axi_rvalid && m_axi_rready;
            hsW     = m_axi_wvalid && m_axi_wready;
            hsWLast = hsW && m_axi_wlast;
            hsB     = m_axi_bvalid && m_axi_bready;
            arWait  = m_axi_arvalid && !m_axi_arready;
            awWait  = m_axi_awvalid && !m_axi_awready;
            @(posedge clk);
            #1;
            if (sawRst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                rOn = 0; wOn = 0; rBeat = 0; arWaitCnt = 0; awWaitCnt = 0;
            end else begin
                if (hsAr) begin
                    m_axi_arready = 0; rOn = 1; rBeat = 0; arWaitCnt = 0;
                end else if (arWait) begin
                    arWaitCnt++;
                    if (arWaitCnt >= cfgStall) m_axi_arready = 1;
                end
                if (rOn) begin
                    if (hsR) rBeat++;
                    if (rBeat >= BLOCKS) begin
                        rOn = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                    end else if (!(m_axi_rvalid && !hsR)) begin
                        m_axi_rvalid = cfgGaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                        m_axi_rdata  = cfgBase + 32'(rBeat);
                        m_axi_rresp  = (rBeat == cfgErrBeat) ? 2'b10 : 2'b00;
                        m_axi_rlast  = (rBeat == cfgLastBeat);
                    end
                end
                if (hsAw) begin
                    m_axi_awready = 0; wOn = 1; awWaitCnt = 0;
                end else if (awWait) begin
                    awWaitCnt++;
                    if (awWaitCnt >= cfgStall) m_axi_awready = 1;
                end
                if (hsB) m_axi_bvalid = 0;
                if (wOn) begin
                    if (hsWLast) begin
                        wOn = 0; m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00;
                    end else begin
                        m_axi_wready = cfgGaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle scoreboard: burst shape, stability of pending valids, beat data and error pulse.
    logic              pAwV, pAwR, pArV, pArR, pWV, pWR, pWLast, pLdV, pLdR;
    logic [31:0]       pAwAddr, pArAddr, pWData;
    logic [LINE_W-1:0] pLine;
    initial begin
        wCnt = 0; rCnt = 0; awDone = 0; ldDueNext = 0; busyDueNext = 0;
        pAwV = 0; pArV = 0; pWV = 0; pLdV = 0;
        forever begin
            @(negedge clk);
            ldDueNow   = ldDueNext;   ldDueNext   = 0;
            busyDueNow = busyDueNext; busyDueNext = 0;
            if (rst) begin
                wCnt = 0; rCnt = 0; awDone = 0;
                pAwV = 0; pArV = 0; pWV = 0; pLdV = 0;
            end else begin
                if (pAwV && !pAwR) begin
                    checkOutput("awvalidHeld", m_axi_awvalid, 1);
                    checkOutput("awaddrHeld", m_axi_awaddr, pAwAddr);
                end
                if (pArV && !pArR) begin
                    checkOutput("arvalidHeld", m_axi_arvalid, 1);
                    checkOutput("araddrHeld", m_axi_araddr, pArAddr);
                end
                if (pWV && !pWR) begin
                    checkOutput("wvalidHeld", m_axi_wvalid, 1);
                    checkOutput("wdataHeld", m_axi_wdata, pWData);
                    checkOutput("wlastHeld", m_axi_wlast, pWLast);
                end
                if (pLdV && !pLdR) begin
                    checkOutput("validLdHeld", valid_ld, 1);
                    checkOutput("lineHeld", data_out_c === pLine, 1);
                end
                if (m_axi_awvalid) begin
                    checkOutput("awaddr", m_axi_awaddr, modelAddr);
                    checkOutput("awlen", m_axi_awlen, 63);
                    checkOutput("awsize", m_axi_awsize, 2);
                    checkOutput("awburst", m_axi_awburst, 1);
                end
                if (m_axi_arvalid) begin
                    checkOutput("araddr", m_axi_araddr, modelAddr);
                    checkOutput("arlen", m_axi_arlen, 63);
                    checkOutput("arsize", m_axi_arsize, 2);
                    checkOutput("arburst", m_axi_arburst, 1);
                end
                if (m_axi_wvalid) begin
                    checkOutput("wstrb", m_axi_wstrb, 4'hF);
                    checkOutput("wAfterAw", awDone, 1);
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    awDone = 1; wCnt = 0;
                end
                if (m_axi_arvalid && m_axi_arready) rCnt = 0;
                if (m_axi_wvalid && m_axi_wready) begin
                    if (wCnt < BLOCKS) begin
                        checkOutput("wdata", m_axi_wdata, modelLine[wCnt*32 +: 32]);
                        checkOutput("wlast", m_axi_wlast, wCnt == BLOCKS - 1);
                    end else begin
                        checkOutput("wBeatCount", wCnt, BLOCKS - 1);
                    end
                    wCnt++;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    if (rCnt == BLOCKS - 1) ldDueNext = 1;
                    rCnt++;
                end
                if (ldDueNow) checkOutput("ldLatency", valid_ld, 1);
                if (busyDueNow) checkOutput("busyFallWb", busy, 0);
                if (m_axi_bvalid && m_axi_bready) begin
                    checkOutput("wBeatsTotal", wCnt, BLOCKS);
                    awDone = 0; busyDueNext = 1;
                end
                if (valid_ld && ready_ld) begin
                    checkOutput("ldLine", data_out_c === modelLine, 1);
                    checkOutput("rBeatsTotal", rCnt, BLOCKS);
                    checkOutput("ldErr", err_out, modelLdErr);
                end else begin
                    checkOutput("errIdle", err_out, 0);
                end
                pAwV = m_axi_awvalid; pAwR = m_axi_awready; pAwAddr = m_axi_awaddr;
                pArV = m_axi_arvalid; pArR = m_axi_arready; pArAddr = m_axi_araddr;
                pWV = m_axi_wvalid; pWR = m_axi_wready; pWData = m_axi_wdata; pWLast = m_axi_wlast;
                pLdV = valid_ld; pLdR = ready_ld; pLine = data_out_c;
            end
        end
    end

    // One cache request from start to finish (or to a reset at a given W beat).
    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] expAligned,
                                 input logic [31:0] base, input int errBeat, input int lastBeat,
                                 input logic gaps, input int stall, input int ldDelay,
                                 input logic expErr, input int resetAtBeat);
        logic done;
        cfgBase = base; cfgErrBeat = errBeat; cfgLastBeat = lastBeat; cfgGaps = gaps; cfgStall = stall;
        modelAddr  = {addr[31:8], 8'h00};
        modelLdErr = (errBeat >= 0 && errBeat < BLOCKS) || (lastBeat != BLOCKS - 1);
        for (int i = 0; i < BLOCKS; i++) modelLine[i*32 +: 32] = base + 32'(i);
        $display("[TB] request rw=%0d addr=0x%08h", isWrite, addr);

        @(posedge clk); #1;
        addr_valid_in = 1; addr_in = addr; rw_in = isWrite;
        if (isWrite) begin
            valid_wb = 1; data_in_c = modelLine;
        end
        @(negedge clk);
        checkOutput("readyWbInIdle", ready_wb, 0);
        @(posedge clk); #1;
        addr_valid_in = 0;
        @(negedge clk);
        checkOutput("busyRise", busy, 1);
        if (isWrite) begin
            checkOutput("readyWb", ready_wb, 1);
            checkOutput("noAwBeforeCapture", m_axi_awvalid, 0);
            @(posedge clk); #1;
            valid_wb = 0;
            @(negedge clk);
            checkOutput("awvalidRise", m_axi_awvalid, 1);
            checkOutput("awaddrLiteral", m_axi_awaddr, expAligned);
            checkOutput("readyWbDrop", ready_wb, 0);
        end else begin
            checkOutput("arvalidLatency", m_axi_arvalid, 1);
            checkOutput("araddrLiteral", m_axi_araddr, expAligned);
            checkOutput("arlenLiteral", m_axi_arlen, 8'd63);
        end

        if (resetAtBeat >= 0) begin
            done = 0;
            for (int c = 0; c < 4000; c++) begin
                @(posedge clk); #1;
                if (wCnt >= resetAtBeat) begin
                    done = 1;
                    break;
                end
            end
            checkOutput("reachedResetBeat", done, 1);
            rst = 1;
            @(negedge clk);
            checkOutput("rstAwvalid", m_axi_awvalid, 0);
            checkOutput("rstWvalid", m_axi_wvalid, 0);
            checkOutput("rstBready", m_axi_bready, 0);
            checkOutput("rstArvalid", m_axi_arvalid, 0);
            checkOutput("rstRready", m_axi_rready, 0);
            checkOutput("rstValidLd", valid_ld, 0);
            checkOutput("rstBusy", busy, 0);
            @(posedge clk); #1;
            rst = 0;
        end else if (isWrite) begin
            done = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if (!busy) begin
                    done = 1;
                    break;
                end
            end
            checkOutput("wbCompletes", done, 1);
        end else begin
            done = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if (valid_ld) begin
                    done = 1;
                    break;
                end
            end
            checkOutput("ldArrives", done, 1);
            for (int c = 0; c < ldDelay; c++) begin
                @(posedge clk); #1;
                addr_valid_in = 1; rw_in = 1; addr_in = 32'hDEAD_BEEF;
                @(negedge clk);
                checkOutput("stallValidLd", valid_ld, 1);
                checkOutput("stallBusy", busy, 1);
                checkOutput("stallIgnoreReq", ready_wb | m_axi_awvalid | m_axi_arvalid, 0);
            end
            @(posedge clk); #1;
            addr_valid_in = 0; ready_ld = 1;
            @(negedge clk);
            checkOutput("ldErrLiteral", err_out, expErr);
            checkOutput("ldWord0", data_out_c[31:0], base);
            checkOutput("ldWord63", data_out_c[63*32 +: 32], base + 32'd63);
            @(posedge clk); #1;
            ready_ld = 0;
            @(negedge clk);
            checkOutput("ldBusyFall", busy, 0);
            checkOutput("ldValidFall", valid_ld, 0);
        end
    endtask

    // Top-level sequence of directed requests.
    initial begin
        rst = 1; addr_valid_in = 0; addr_in = '0; rw_in = 0; valid_wb = 0; ready_ld = 0; data_in_c = '0;
        cfgBase = '0; cfgErrBeat = -1; cfgLastBeat = 63; cfgGaps = 0; cfgStall = 0;
        modelAddr = '0; modelLine = '0; modelLdErr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetValidLd", valid_ld, 0);
        checkOutput("resetReadyWb", ready_wb, 0);
        checkOutput("resetAwvalid", m_axi_awvalid, 0);
        checkOutput("resetWvalid", m_axi_wvalid, 0);
        checkOutput("resetBready", m_axi_bready, 0);
        checkOutput("resetArvalid", m_axi_arvalid, 0);
        checkOutput("resetRready", m_axi_rready, 0);
        checkOutput("resetErr", err_out, 0);
        @(posedge clk); #1;
        rst = 0;

        applyStimulus(0, 32'h0000_1234, 32'h0000_1200, 32'h0000_0000, -1, 63, 0, 0, 0, 0, -1);
        applyStimulus(1, 32'h0000_ABCD, 32'h0000_AB00, 32'hA500_0000, -1, 63, 0, 0, 0, 0, -1);
        applyStimulus(0, 32'h1234_5678, 32'h1234_5600, 32'h5000_0000, -1, 63, 1, 7, 0, 0, -1);
        applyStimulus(1, 32'h8000_00FF, 32'h8000_0000, 32'hC0DE_0000, -1, 63, 1, 7, 0, 0, -1);
        applyStimulus(0, 32'h0000_2040, 32'h0000_2000, 32'h1000_0000, 10, 63, 1, 0, 0, 1, -1);
        applyStimulus(0, 32'h0000_3000, 32'h0000_3000, 32'h2000_0000, -1, 62, 0, 0, 0, 1, -1);
        applyStimulus(0, 32'h0000_4321, 32'h0000_4300, 32'h3000_0000, -1, 63, 0, 0, 5, 0, -1);
        applyStimulus(1, 32'h0000_5555, 32'h0000_5500, 32'h4000_0000, -1, 63, 1, 0, 0, 0, 20);
        applyStimulus(0, 32'h0000_6666, 32'h0000_6600, 32'h6000_0000, -1, 63, 1, 0, 0, 0, -1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global time bound in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
